// File: rtl/atm_keypad_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : atm_keypad_tx                                              |
// | Description : Front-panel keypad sequencer for the ATM entry interface.  |
// |               Streams PIN digits to the controller, then collects the    |
// |               transaction type and a saturating decimal amount.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module atm_keypad_tx #(
  parameter int PIN_LEN     = 4,
  parameter int MAX_DIGITS  = 5,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        card_in,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  input  logic        pin_ok,
  input  logic        pin_incorrecto,
  input  logic        bloqueo,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic        tipo_trans,
  output logic [15:0] monto,
  output logic        monto_stb,
  output logic        locked,
  output logic        timeout_evt
);

  localparam int PCW = $clog2(PIN_LEN + 1);
  localparam int NDW = $clog2(MAX_DIGITS + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] KEY_ENTER    = 4'hA;
  localparam logic [3:0] KEY_CLEAR    = 4'hB;
  localparam logic [3:0] KEY_CANCEL   = 4'hC;
  localparam logic [3:0] KEY_WITHDRAW = 4'hD;
  localparam logic [3:0] KEY_DEPOSIT  = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PIN      = 3'd1,
    S_PIN_WAIT = 3'd2,
    S_SEL      = 3'd3,
    S_AMT      = 3'd4,
    S_SEND     = 3'd5,
    S_DONE     = 3'd6,
    S_LOCK     = 3'd7
  } state_t;

  state_t          state, state_nxt;
  logic [PCW-1:0]  pin_cnt, pin_cnt_nxt;
  logic [15:0]     acc, acc_nxt;
  logic [NDW-1:0]  ndig, ndig_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;

  logic [3:0]      digito_nxt;
  logic            digito_stb_nxt;
  logic            tipo_nxt;
  logic [15:0]     monto_nxt;
  logic            monto_stb_nxt;
  logic            timeout_nxt;
  logic            key_ready_nxt;
  logic            locked_nxt;

  logic            key_acc;
  logic            is_digit;
  logic            active;
  logic            tmo;
  logic [19:0]     amt_calc;

  assign key_acc  = key_valid & key_ready;
  assign is_digit = (key_code <= 4'd9);
  assign active   = (state == S_PIN) || (state == S_SEL) || (state == S_AMT);
  assign tmo      = active && (tcnt == TW'(TIMEOUT_CYC - 1));
  // 20 bits hold 65535*10+9 without overflow, so saturation is a plain compare
  assign amt_calc = 20'(acc) * 20'd10 + 20'(key_code);

  // Next-state and next-output decode, in priority order bloqueo > card > timeout > key
  always_comb begin
    state_nxt      = state;
    pin_cnt_nxt    = pin_cnt;
    acc_nxt        = acc;
    ndig_nxt       = ndig;
    digito_nxt     = digito;
    digito_stb_nxt = 1'b0;
    tipo_nxt       = tipo_trans;
    monto_nxt      = monto;
    monto_stb_nxt  = 1'b0;
    timeout_nxt    = 1'b0;

    if (bloqueo) begin
      state_nxt = S_LOCK;
    end else if ((state != S_LOCK) && !card_in) begin
      state_nxt = S_IDLE;
      acc_nxt   = '0;
      ndig_nxt  = '0;
    end else if (tmo) begin
      state_nxt   = S_IDLE;
      timeout_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt   = S_PIN;
          pin_cnt_nxt = '0;
          acc_nxt     = '0;
          ndig_nxt    = '0;
        end
        S_PIN: begin
          if (key_acc) begin
            if (is_digit) begin
              digito_nxt     = key_code;
              digito_stb_nxt = 1'b1;
              pin_cnt_nxt    = pin_cnt + PCW'(1);
              if (pin_cnt == PCW'(PIN_LEN - 1)) begin
                state_nxt = S_PIN_WAIT;
              end
            end else if (key_code == KEY_CANCEL) begin
              state_nxt = S_IDLE;
            end
          end
        end
        S_PIN_WAIT: begin
          if (pin_ok) begin
            state_nxt = S_SEL;
          end else if (pin_incorrecto) begin
            state_nxt   = S_PIN;
            pin_cnt_nxt = '0;
          end
        end
        S_SEL: begin
          if (key_acc) begin
            if (key_code == KEY_WITHDRAW) begin
              tipo_nxt  = 1'b1;
              state_nxt = S_AMT;
              acc_nxt   = '0;
              ndig_nxt  = '0;
            end else if (key_code == KEY_DEPOSIT) begin
              tipo_nxt  = 1'b0;
              state_nxt = S_AMT;
              acc_nxt   = '0;
              ndig_nxt  = '0;
            end else if (key_code == KEY_CANCEL) begin
              state_nxt = S_IDLE;
            end
          end
        end
        S_AMT: begin
          if (key_acc) begin
            if (is_digit) begin
              if (ndig < NDW'(MAX_DIGITS)) begin
                acc_nxt  = (amt_calc > 20'd65535) ? 16'hFFFF : amt_calc[15:0];
                ndig_nxt = ndig + NDW'(1);
              end
            end else if (key_code == KEY_CLEAR) begin
              acc_nxt  = '0;
              ndig_nxt = '0;
            end else if (key_code == KEY_CANCEL) begin
              state_nxt = S_IDLE;
            end else if ((key_code == KEY_ENTER) && (ndig != '0)) begin
              state_nxt     = S_SEND;
              monto_nxt     = acc;
              monto_stb_nxt = 1'b1;
            end
          end
        end
        S_SEND:  state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end

    // Inactivity timer restarts on any state change or accepted key
    if ((state_nxt != state) || key_acc || !active) begin
      tcnt_nxt = '0;
    end else begin
      tcnt_nxt = tcnt + TW'(1);
    end

    key_ready_nxt = (state_nxt == S_PIN) || (state_nxt == S_SEL) || (state_nxt == S_AMT);
    locked_nxt    = (state_nxt == S_LOCK);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pin_cnt     <= '0;
      acc         <= '0;
      ndig        <= '0;
      tcnt        <= '0;
      digito      <= '0;
      digito_stb  <= 1'b0;
      tipo_trans  <= 1'b0;
      monto       <= '0;
      monto_stb   <= 1'b0;
      timeout_evt <= 1'b0;
      key_ready   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pin_cnt     <= pin_cnt_nxt;
      acc         <= acc_nxt;
      ndig        <= ndig_nxt;
      tcnt        <= tcnt_nxt;
      digito      <= digito_nxt;
      digito_stb  <= digito_stb_nxt;
      tipo_trans  <= tipo_nxt;
      monto       <= monto_nxt;
      monto_stb   <= monto_stb_nxt;
      timeout_evt <= timeout_nxt;
      key_ready   <= key_ready_nxt;
      locked      <= locked_nxt;
    end
  end

endmodule
`default_nettype wire
